// File: rtl/lcd_tile_layer.sv
// Tile-map display layer: bus-accessible tile map and pattern RAM with a
// fixed four-stage pixel lookup pipeline that feeds the LCD compositor.
module lcd_tile_layer #(
  parameter int unsigned SCREEN_W    = 480,
  parameter int unsigned SCREEN_H    = 272,
  parameter int unsigned TILE_W_LOG2 = 3,
  parameter int unsigned TILE_H_LOG2 = 3,
  parameter int unsigned NUM_TILES   = 16,
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_i,
  output logic              ready,
  output logic [31:0]       data_o,
  input  logic              pix_en,
  input  logic [9:0]        pos_x,
  input  logic [8:0]        pos_y,
  output logic              pix_valid,
  output logic [15:0]       rgb,
  output logic              opaque
);

  localparam int unsigned COLS      = SCREEN_W >> TILE_W_LOG2;
  localparam int unsigned ROWS      = SCREEN_H >> TILE_H_LOG2;
  localparam int unsigned ENTRIES   = COLS * ROWS;
  localparam int unsigned MAP_WORDS = (ENTRIES + 3) / 4;
  localparam int unsigned PAT_WORDS = NUM_TILES << (TILE_W_LOG2 + TILE_H_LOG2 - 1);
  localparam int unsigned IDX_W     = $clog2(ENTRIES);
  localparam int unsigned MAP_AW    = $clog2(MAP_WORDS);
  localparam int unsigned PAT_AW    = $clog2(PAT_WORDS);
  localparam int unsigned PIX_W     = 4 + TILE_W_LOG2 + TILE_H_LOG2;
  localparam int unsigned BUS_AW    = ADDR_W - 3;
  localparam int unsigned TW        = TILE_W_LOG2;
  localparam int unsigned TH        = TILE_H_LOG2;

  logic [31:0] map_mem [MAP_WORDS];
  logic [31:0] pat_mem [PAT_WORDS];

  // Bus decode
  logic              accept;
  logic              bus_pat;
  logic [BUS_AW-1:0] bus_word;
  logic              map_hit;
  logic              pat_hit;
  logic              unused_addr;

  assign bus_pat     = addr[ADDR_W-1];
  assign bus_word    = addr[ADDR_W-2:2];
  assign accept      = sel & ~ready;
  assign map_hit     = ~bus_pat & (32'(bus_word) < MAP_WORDS);
  assign pat_hit     = bus_pat & (32'(bus_word) < PAT_WORDS);
  assign unused_addr = ^addr[1:0];

  // Byte-strobed bus writes; out-of-range words are silently dropped
  always_ff @(posedge clk) begin
    if (accept && (wstrb != 4'b0000)) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          if (map_hit) map_mem[MAP_AW'(bus_word)][8*b +: 8] <= data_i[8*b +: 8];
          if (pat_hit) pat_mem[PAT_AW'(bus_word)][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
  end

  // Bus handshake and read data; data_o holds until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready  <= 1'b0;
      data_o <= '0;
    end else begin
      ready <= accept;
      if (accept && (wstrb == 4'b0000)) begin
        if (map_hit)      data_o <= map_mem[MAP_AW'(bus_word)];
        else if (pat_hit) data_o <= pat_mem[PAT_AW'(bus_word)];
        else              data_o <= '0;
      end
    end
  end

  // S1 combinational: screen bound and map entry index
  logic             in_c;
  logic [IDX_W-1:0] idx_c;

  always_comb begin
    in_c  = (32'(pos_x) < SCREEN_W) && (32'(pos_y) < SCREEN_H);
    idx_c = '0;
    if (in_c) begin
      idx_c = IDX_W'((32'(pos_y) >> TH) * COLS + (32'(pos_x) >> TW));
    end
  end

  logic             v1, in1;
  logic [IDX_W-1:0] idx1;
  logic [TW-1:0]    tx1;
  logic [TH-1:0]    ty1;

  // S1 register: request coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      in1  <= 1'b0;
      idx1 <= '0;
      tx1  <= '0;
      ty1  <= '0;
    end else begin
      v1   <= pix_en;
      in1  <= in_c;
      idx1 <= idx_c;
      tx1  <= pos_x[TW-1:0];
      ty1  <= pos_y[TH-1:0];
    end
  end

  logic          v2, in2;
  logic [31:0]   ent_word2;
  logic [1:0]    esel2;
  logic [TW-1:0] tx2;
  logic [TH-1:0] ty2;

  // S2 register: map word read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      in2       <= 1'b0;
      ent_word2 <= '0;
      esel2     <= '0;
      tx2       <= '0;
      ty2       <= '0;
    end else begin
      v2        <= v1;
      in2       <= in1;
      ent_word2 <= map_mem[MAP_AW'(idx1[IDX_W-1:2])];
      esel2     <= idx1[1:0];
      tx2       <= tx1;
      ty2       <= ty1;
    end
  end

  // S3 combinational: entry decode, flips and pattern index
  logic [7:0]       ent_c;
  logic [TW-1:0]    txf_c;
  logic [TH-1:0]    tyf_c;
  logic [PIX_W-1:0] pidx_c;
  logic             draw_c;
  logic             pat_ok_c;

  always_comb begin
    ent_c = 8'h00;
    case (esel2)
      2'd0:    ent_c = ent_word2[7:0];
      2'd1:    ent_c = ent_word2[15:8];
      2'd2:    ent_c = ent_word2[23:16];
      default: ent_c = ent_word2[31:24];
    endcase
    txf_c    = ent_c[4] ? ~tx2 : tx2;
    tyf_c    = ent_c[5] ? ~ty2 : ty2;
    pidx_c   = {ent_c[3:0], tyf_c, txf_c};
    draw_c   = in2 & ent_c[7] & (32'(ent_c[3:0]) < NUM_TILES);
    pat_ok_c = 32'(pidx_c[PIX_W-1:1]) < PAT_WORDS;
  end

  logic        v3, draw3, half3;
  logic [31:0] pat_word3;

  // S3 register: pattern word read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3        <= 1'b0;
      draw3     <= 1'b0;
      half3     <= 1'b0;
      pat_word3 <= '0;
    end else begin
      v3        <= v2;
      draw3     <= draw_c;
      half3     <= pidx_c[0];
      pat_word3 <= pat_ok_c ? pat_mem[PAT_AW'(pidx_c[PIX_W-1:1])] : '0;
    end
  end

  // S4 combinational: pixel select and colour key
  logic [15:0] pix_c;
  logic        shown_c;

  always_comb begin
    pix_c   = half3 ? pat_word3[31:16] : pat_word3[15:0];
    shown_c = v3 & draw3 & (pix_c != TRANSPARENT);
  end

  // S4 register: outputs, rgb forced to 0 when see-through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      rgb       <= '0;
      opaque    <= 1'b0;
    end else begin
      pix_valid <= v3;
      opaque    <= shown_c;
      rgb       <= shown_c ? pix_c : 16'h0000;
    end
  end

endmodule

// File: tb/tb_lcd_tile_layer.sv
// Self-checking bench for lcd_tile_layer: behavioural memory/pixel model,
// per-cycle output compare, and directed bus/pixel vectors.
module tb_lcd_tile_layer;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [3:0]  wstrb;
  logic [11:0] addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;
  logic        pix_en;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic        pix_valid;
  logic [15:0] rgb;
  logic        opaque;

  int n_checks = 0;
  int n_errors = 0;
  int vcount   = 0;

  logic [31:0] map_m [510];
  logic [31:0] pat_m [512];
  logic [17:0] dl [4];

  lcd_tile_layer dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .wstrb(wstrb), .addr(addr),
    .data_i(data_i), .ready(ready), .data_o(data_o), .pix_en(pix_en),
    .pos_x(pos_x), .pos_y(pos_y), .pix_valid(pix_valid), .rgb(rgb),
    .opaque(opaque)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level pixel model: returns {opaque, rgb}
  function automatic logic [16:0] model_pix(input int x, input int y);
    int e, tx, ty, id, g;
    logic [31:0] w;
    logic [7:0]  ent;
    logic [15:0] p;
    if (x >= 480 || y >= 272) return 17'h0;
    e = (y / 8) * 60 + x / 8;
    w = map_m[e / 4];
    ent = w[(e % 4) * 8 +: 8];
    if (!ent[7]) return 17'h0;
    id = int'(ent[3:0]);
    if (id >= 16) return 17'h0;
    tx = x % 8;
    ty = y % 8;
    if (ent[4]) tx = 7 - tx;
    if (ent[5]) ty = 7 - ty;
    g = id * 64 + ty * 8 + tx;
    w = pat_m[g / 2];
    p = (g % 2 == 1) ? w[31:16] : w[15:0];
    if (p == 16'hF81F) return 17'h0;
    return {1'b1, p};
  endfunction

  task automatic mdl_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    w = int'(a[10:2]);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (!a[11] && w < 510) map_m[w][8*b +: 8] = d[8*b +: 8];
        if (a[11] && w < 512)  pat_m[w][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [11:0] a);
    int w;
    w = int'(a[10:2]);
    if (!a[11]) return (w < 510) ? map_m[w] : 32'h0;
    return pat_m[w];
  endfunction

  // Expected outputs delayed by the fixed 4-clock latency; reset flushes it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dl[i] <= 18'h0;
    end else begin
      dl[0] <= {pix_en, pix_en ? model_pix(int'(pos_x), int'(pos_y)) : 17'h0};
      dl[1] <= dl[0];
      dl[2] <= dl[1];
      dl[3] <= dl[2];
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("pix_valid", {31'h0, pix_valid}, {31'h0, dl[3][17]});
    if (dl[3][17]) begin
      chk("rgb", {16'h0, rgb}, {16'h0, dl[3][15:0]});
      chk("opaque", {31'h0, opaque}, {31'h0, dl[3][16]});
    end
    if (pix_valid) vcount++;
  end

  // Called at posedge+1; request accepted at the next edge
  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    chk("ready_idle", {31'h0, ready}, 32'h0);
    sel = 1'b1; addr = a; data_i = d; wstrb = s;
    @(posedge clk); #1;
    chk("wr_ready", {31'h0, ready}, 32'h1);
    sel = 1'b0; wstrb = 4'h0;
    mdl_wr(a, d, s);
    @(posedge clk); #1;
    chk("wr_ready_pulse", {31'h0, ready}, 32'h0);
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] d);
    chk("ready_idle", {31'h0, ready}, 32'h0);
    sel = 1'b1; addr = a; wstrb = 4'h0;
    @(posedge clk); #1;
    chk("rd_ready", {31'h0, ready}, 32'h1);
    d = data_o;
    chk("rd_model", data_o, mdl_rd(a));
    sel = 1'b0;
    @(posedge clk); #1;
    chk("rd_ready_pulse", {31'h0, ready}, 32'h0);
    chk("rd_data_hold", data_o, d);
  endtask

  task automatic pix_check(input int x, input int y, input logic [15:0] er, input logic eo, input string nm);
    pos_x = 10'(x); pos_y = 9'(y); pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_valid"}, {31'h0, pix_valid}, 32'h1);
    chk({nm, "_rgb"}, {16'h0, rgb}, {16'h0, er});
    chk({nm, "_opaque"}, {31'h0, opaque}, {31'h0, eo});
  endtask

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    logic [31:0] rd;
    for (int i = 0; i < 510; i++) map_m[i] = 32'h0;
    for (int i = 0; i < 512; i++) pat_m[i] = 32'h0;
    sel = 0; wstrb = 0; addr = 0; data_i = 0; pix_en = 0; pos_x = 0; pos_y = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_pix_valid", {31'h0, pix_valid}, 32'h0);
    chk("rst_rgb", {16'h0, rgb}, 32'h0);
    chk("rst_opaque", {31'h0, opaque}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bring both RAMs to a known all-zero image
    for (int w = 0; w < 510; w++) bus_wr(12'(w * 4), 32'h0, 4'hF);
    for (int w = 0; w < 512; w++) bus_wr(12'(32'h800 + w * 4), 32'h0, 4'hF);

    // Map write/read with byte strobes
    bus_wr(12'h010, 32'hA1B2C3D4, 4'hF);
    bus_rd(12'h010, rd);
    chk("map_rd_full", rd, 32'hA1B2C3D4);
    bus_wr(12'h010, 32'h0000EE00, 4'b0010);
    bus_rd(12'h010, rd);
    chk("map_rd_strb", rd, 32'hA1B2EED4);

    // Out-of-range map word is dropped and reads 0
    bus_wr(12'h7F8, 32'hFFFFFFFF, 4'hF);
    bus_rd(12'h7F8, rd);
    chk("oor_rd", rd, 32'h0);

    // sel held through ready: next acceptance only two edges later
    sel = 1'b1; addr = 12'h010; wstrb = 4'h0;
    @(posedge clk); #1;
    chk("hold_ready1", {31'h0, ready}, 32'h1);
    @(posedge clk); #1;
    chk("hold_ready_gap", {31'h0, ready}, 32'h0);
    @(posedge clk); #1;
    chk("hold_ready2", {31'h0, ready}, 32'h1);
    chk("hold_data", data_o, 32'hA1B2EED4);
    sel = 1'b0;
    @(posedge clk); #1;

    // Tile 1 pixel value equals its index within the tile
    for (int j = 0; j < 32; j++)
      bus_wr(12'(32'h800 + (32 + j) * 4), {16'(2 * j + 1), 16'(2 * j)}, 4'hF);

    bus_wr(12'h000, 32'h00000081, 4'b0001);
    pix_check(3, 2, 16'h0013, 1'b1, "basic");
    bus_wr(12'h000, 32'h00000091, 4'b0001);
    pix_check(3, 2, 16'h0014, 1'b1, "hflip");
    bus_wr(12'h000, 32'h000000B1, 4'b0001);
    pix_check(3, 2, 16'h002C, 1'b1, "hvflip");

    // Transparency, disabled entry and screen bounds
    bus_wr(12'h900, 32'h0000F81F, 4'b0011);
    bus_wr(12'h000, 32'h00008200, 4'b0010);
    bus_wr(12'h000, 32'h00010000, 4'b0100);
    bus_wr(12'h7F4, 32'h81000000, 4'b1000);
    pix_check(8, 0, 16'h0000, 1'b0, "transparent");
    pix_check(9, 0, 16'h0000, 1'b1, "black_opaque");
    pix_check(16, 0, 16'h0000, 1'b0, "disabled");
    pix_check(480, 0, 16'h0000, 1'b0, "x_oob");
    pix_check(0, 272, 16'h0000, 1'b0, "y_oob");
    pix_check(479, 271, 16'h003F, 1'b1, "corner");

    // Streaming a full row with a concurrent bus write
    bus_wr(12'h014, 32'h91B18182, 4'hF);
    vcount = 0;
    fork
      begin
        for (int x = 0; x < 480; x++) begin
          pos_x = 10'(x); pos_y = 9'd5; pix_en = 1'b1;
          @(posedge clk); #1;
        end
        pix_en = 1'b0;
      end
      begin
        repeat (100) @(posedge clk);
        #1;
        bus_wr(12'(32'h800 + (5 * 32 + 3) * 4), $urandom, 4'hF);
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("stream_count", 32'(vcount), 32'd480);
    bus_rd(12'(32'h800 + (5 * 32 + 3) * 4), rd);

    // Reset with three requests in flight and a read pending
    pos_x = 10'd3; pos_y = 9'd2; pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pix_en = 1'b0;
    sel = 1'b1; addr = 12'h010; wstrb = 4'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'h0, ready}, 32'h0);
    chk("mid_rst_data_o", data_o, 32'h0);
    chk("mid_rst_pix_valid", {31'h0, pix_valid}, 32'h0);
    chk("mid_rst_rgb", {16'h0, rgb}, 32'h0);
    chk("mid_rst_opaque", {31'h0, opaque}, 32'h0);
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post_rst_ready", {31'h0, ready}, 32'h0);
      chk("post_rst_pix_valid", {31'h0, pix_valid}, 32'h0);
    end
    bus_rd(12'h010, rd);
    chk("map_retained", rd, 32'hA1B2EED4);
    pix_check(3, 2, 16'h002C, 1'b1, "post_rst_pix");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
